// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues word fetches under a credit limit, buffers returned
// {pc,inst} pairs for decode and drops in-flight returns made stale by a redirect.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CSW = CW + 1;
    localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OW  = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0]  MAX_OUT_C = OW'(MAX_OUT);
    localparam logic [CSW-1:0] DEPTH_C   = CSW'(DEPTH);
    localparam logic [PW-1:0]  PEND_LAST = PW'(MAX_OUT - 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pend_pc   [MAX_OUT];
    logic [PW-1:0] pend_wr, pend_rd;
    logic [OW-1:0] outstanding, outstanding_nxt;
    logic [OW-1:0] discard;
    logic          accept, ret, drop, push, pop;

    // The pending FIFO may hold a non power-of-two number of entries, so wrap explicitly.
    function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
        return (p == PEND_LAST) ? '0 : p + PW'(1);
    endfunction

    assign inst_req  = !reset && !redirect && (outstanding < MAX_OUT_C)
                       && ((CSW'(count) + CSW'(outstanding)) < DEPTH_C);
    assign inst_addr = fetch_pc;
    assign accept    = inst_req && inst_addr_ok;
    assign ret       = inst_data_ok && (outstanding != '0);
    assign drop      = ret && (discard != '0);
    assign push      = ret && !drop;

    assign out_valid = !reset && (count != '0);
    assign out_pc    = fifo_pc[rd_ptr];
    assign out_inst  = fifo_inst[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_comb begin
        outstanding_nxt = outstanding;
        if (accept && !ret)
            outstanding_nxt = outstanding + OW'(1);
        else if (!accept && ret)
            outstanding_nxt = outstanding - OW'(1);
    end

    // Storage carries no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= pend_pc[pend_rd];
            fifo_inst[wr_ptr] <= inst_rdata;
        end
        if (accept)
            pend_pc[pend_wr] <= fetch_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pend_wr     <= '0;
            pend_rd     <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (accept)
                pend_wr <= pend_inc(pend_wr);
            if (ret)
                pend_rd <= pend_inc(pend_rd);

            if (redirect) begin
                // Everything still on the bus after this cycle belongs to the old path.
                fetch_pc <= redirect_pc;
                discard  <= outstanding_nxt;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (drop)
                    discard <= discard - OW'(1);
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed bus/decode patterns checked every cycle against a
// queue-based model, plus literal expectations at the interesting points.
module tb_inst_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        inst_data_ok = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready)
    );

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;

    // Bus responder: addresses accepted by the bus, returned in order.
    logic [31:0] bus_q[$];

    // Model: fetch address, in-flight addresses, how many of them are stale, delivered queue.
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_infl[$];
    int          m_stale = 0;
    logic [31:0] m_fifo[$];

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h13572468;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic exp_req, exp_valid, acc, pop;
        logic [31:0] p;
        exp_req   = !reset && !redirect && (m_infl.size() < MAX_OUT)
                    && ((m_fifo.size() + m_infl.size()) < DEPTH);
        exp_valid = !reset && (m_fifo.size() > 0);
        chk("inst_req", 32'(inst_req), 32'(exp_req));
        if (exp_req) chk("inst_addr", inst_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("out_pc", out_pc, m_fifo[0]);
            chk("out_inst", out_inst, word_of(m_fifo[0]));
        end
        if (reset) begin
            m_pc = RESET_PC;
            m_infl.delete();
            m_fifo.delete();
            m_stale = 0;
            return;
        end
        acc = exp_req && inst_addr_ok;
        pop = exp_valid && out_ready;
        if (pop) void'(m_fifo.pop_front());
        if (inst_data_ok && m_infl.size() > 0) begin
            p = m_infl.pop_front();
            if (m_stale > 0) m_stale--;
            else m_fifo.push_back(p);
        end
        if (acc) begin
            m_infl.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        if (redirect) begin
            m_fifo.delete();
            m_pc = redirect_pc;
            m_stale = m_infl.size();
        end
    endtask

    // One clock cycle: drive at negedge, check/advance model 1ns later (well before posedge).
    task automatic cycle(input int rst, input int aok, input int dok, input int rdy,
                         input int redir, input logic [31:0] rpc);
        @(negedge clk);
        reset        = (rst != 0);
        inst_addr_ok = (aok != 0);
        out_ready    = (rdy != 0);
        redirect     = (redir != 0);
        redirect_pc  = rpc;
        inst_data_ok = (dok != 0) && (bus_q.size() > 0);
        inst_rdata   = inst_data_ok ? word_of(bus_q[0]) : 32'h0;
        #1;
        model_step();
        if (rst != 0) begin
            bus_q.delete();
        end else begin
            if (inst_req && inst_addr_ok) begin
                bus_q.push_back(inst_addr);
                acc_cnt++;
            end
            if (inst_data_ok) void'(bus_q.pop_front());
        end
    endtask

    task automatic run(input int n, input int aok, input int dok, input int rdy);
        for (int k = 0; k < n; k++) cycle(0, aok, dok, rdy, 0, 32'h0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 32'h0);
        cycle(1, 0, 0, 0, 0, 32'h0);
    endtask

    logic [15:0] pat_a = 16'b1101_1011_1110_0111;
    logic [11:0] pat_d = 12'b1011_0111_1101;
    logic [9:0]  pat_r = 10'b11_0110_1011;

    initial begin
        // Reset state
        cycle(1, 1, 1, 1, 0, 32'h0);
        chk("rst_req", 32'(inst_req), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        cycle(1, 1, 1, 1, 0, 32'h0);

        // Streaming from RESET_PC, one per cycle after a 2-cycle fill
        cycle(0, 1, 1, 1, 0, 32'h0);
        chk("first_req", 32'(inst_req), 32'h1);
        chk("first_addr", inst_addr, 32'hbfc00000);
        cycle(0, 1, 1, 1, 0, 32'h0);
        chk("second_addr", inst_addr, 32'hbfc00004);
        chk("fill_valid", 32'(out_valid), 32'h0);
        cycle(0, 1, 1, 1, 0, 32'h0);
        chk("stream_pc0", out_pc, 32'hbfc00000);
        cycle(0, 1, 1, 1, 0, 32'h0);
        chk("stream_pc1", out_pc, 32'hbfc00004);
        run(6, 1, 1, 1);
        // Redirect while an entry is being consumed
        cycle(0, 1, 1, 1, 1, 32'h00400000);
        chk("redir_req", 32'(inst_req), 32'h0);
        run(6, 1, 1, 1);

        // Decode stalled: queue fills with exactly DEPTH accepted requests
        do_reset();
        acc_cnt = 0;
        run(10, 1, 1, 0);
        chk("full_accepts", 32'(acc_cnt), 32'd4);
        chk("full_req", 32'(inst_req), 32'h0);
        chk("full_head", out_pc, 32'hbfc00000);
        run(6, 1, 1, 1);

        // Redirect with two outstanding, no returns yet
        do_reset();
        cycle(0, 1, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 1, 32'h80001000);
        cycle(0, 1, 1, 0, 0, 32'h0);
        chk("r2_blocked", 32'(inst_req), 32'h0);
        cycle(0, 1, 1, 0, 0, 32'h0);
        chk("r2_newaddr", inst_addr, 32'h80001000);
        cycle(0, 1, 1, 0, 0, 32'h0);
        chk("r2_novalid", 32'(out_valid), 32'h0);
        cycle(0, 1, 1, 0, 0, 32'h0);
        chk("r2_head_pc", out_pc, 32'h80001000);
        chk("r2_head_inst", out_inst, 32'h03575b97);
        run(6, 1, 1, 1);

        // Accept and return in the same cycle
        do_reset();
        cycle(0, 1, 0, 0, 0, 32'h0);
        cycle(0, 1, 1, 0, 0, 32'h0);
        cycle(0, 0, 0, 0, 0, 32'h0);
        chk("same_valid", 32'(out_valid), 32'h1);
        chk("same_req", 32'(inst_req), 32'h1);
        chk("same_addr", inst_addr, 32'hbfc00008);
        run(6, 1, 1, 1);

        // Address wrap, and redirect with nothing outstanding
        do_reset();
        cycle(0, 0, 0, 1, 1, 32'hfffffff8);
        chk("wrap_redir_req", 32'(inst_req), 32'h0);
        cycle(0, 1, 1, 1, 0, 32'h0);
        chk("wrap_addr0", inst_addr, 32'hfffffff8);
        cycle(0, 1, 1, 1, 0, 32'h0);
        cycle(0, 1, 1, 1, 0, 32'h0);
        chk("wrap_addr", inst_addr, 32'h00000000);
        chk("wrap_head", out_pc, 32'hfffffff8);
        run(6, 1, 1, 1);

        // Redirect in the cycle a return arrives with two outstanding
        do_reset();
        cycle(0, 1, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 0, 32'h0);
        cycle(0, 0, 1, 1, 1, 32'h80002000);
        cycle(0, 1, 1, 1, 0, 32'h0);
        chk("rd_addr", inst_addr, 32'h80002000);
        chk("rd_novalid0", 32'(out_valid), 32'h0);
        cycle(0, 1, 1, 1, 0, 32'h0);
        chk("rd_novalid1", 32'(out_valid), 32'h0);
        cycle(0, 1, 1, 1, 0, 32'h0);
        chk("rd_head", out_pc, 32'h80002000);
        run(6, 1, 1, 1);

        // Back-to-back redirects
        do_reset();
        cycle(0, 1, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 0, 32'h0);
        cycle(0, 0, 0, 0, 1, 32'h00009000);
        cycle(0, 0, 1, 0, 1, 32'h0000a000);
        cycle(0, 1, 1, 0, 0, 32'h0);
        chk("b2b_addr", inst_addr, 32'h0000a000);
        run(8, 1, 1, 1);

        // Irregular bus/decode handshakes with redirects and a mid-run reset
        do_reset();
        for (int i = 0; i < 60; i++) begin
            cycle((i == 30) ? 1 : 0, int'(pat_a[i % 16]), int'(pat_d[i % 12]),
                  int'(pat_r[i % 10]), (i == 12 || i == 13 || i == 41) ? 1 : 0,
                  32'h00010000 + 32'(i * 64));
        end
        run(12, 1, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
